// File: rtl/async_fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter that shares the async_fifo write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST words and never issues a write while the FIFO reports full.
module async_fifo_write_arbiter #(
    parameter int BITS      = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    write_clk,
    input  logic                    write_rst_n,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    p_write_en,
    output logic [BITS-1:0]         p_write_data,
    input  logic                    p_write_full,
    output logic [NUM_REQ-1:0]      grant_onehot,
    output logic [31:0]             word_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   burst_cnt;
    logic [IDX_W-1:0]   winner;
    logic               cur_valid;
    logic               transfer;
    logic               burst_done;
    logic               release_grant;

    // Search starts just after the last released grant so every requester gets its turn.
    always_comb begin
        int idx;
        logic found;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign cur_valid     = req_valid[grant_idx];
    assign transfer      = (state == BURST) && cur_valid && !p_write_full && arb_en;
    assign burst_done    = transfer && (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign release_grant = burst_done || !cur_valid || !arb_en;

    // NOTE: handshake outputs are decoded from registered state, so the async reset
    // clears them at once without waiting for a clock edge.
    assign p_write_en   = transfer;
    assign req_ready    = grant_onehot & {NUM_REQ{transfer}};
    assign p_write_data = (state == BURST) ? req_data[grant_idx*BITS +: BITS] : '0;

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state        <= IDLE;
            grant_idx    <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            burst_cnt    <= '0;
            grant_onehot <= '0;
            word_count   <= '0;
        end else begin
            if (transfer) begin
                word_count <= word_count + 32'd1;
            end
            unique case (state)
                IDLE: begin
                    if (arb_en && (|req_valid)) begin
                        grant_idx    <= winner;
                        grant_onehot <= NUM_REQ'(1) << winner;
                        burst_cnt    <= '0;
                        state        <= BURST;
                    end
                end
                BURST: begin
                    if (release_grant) begin
                        state        <= IDLE;
                        last_grant   <= grant_idx;
                        burst_cnt    <= '0;
                        grant_onehot <= '0;
                    end else if (transfer) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
